// File: rtl/alu_cmd_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_cmd_seq_pkg;

    localparam int unsigned DW = 8;

    // ALU select encodings
    typedef enum logic [2:0] {
        OP_CLR   = 3'd0,
        OP_BSUBA = 3'd1,
        OP_ASUBB = 3'd2,
        OP_ADD   = 3'd3,
        OP_XOR   = 3'd4,
        OP_OR    = 3'd5,
        OP_AND   = 3'd6,
        OP_SET   = 3'd7
    } alu_op_t;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // One queued command: {acc_sel, op, a, b} = 20 bits
    typedef struct packed {
        logic          acc_sel;
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    // Operand a for the ALU: accumulator or the command's own operand
    function automatic logic [DW-1:0] pick_a(input cmd_t c, input logic [DW-1:0] acc);
        return c.acc_sel ? acc : c.a;
    endfunction

endpackage

// File: rtl/alu_cmd_seq_fifo.sv
// Synchronous command FIFO with occupancy count; full/empty derived from the count.
module alu_cmd_fifo
    import alu_cmd_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned W     = CMD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Full is taken from the registered count, so a same-cycle pop never lets a push through when full
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH (power of two); count tracks occupancy 0..DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer: queues ALU commands, issues one at a time, captures result and flags.
module alu_cmd_seq
    import alu_cmd_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    input  logic          cmd_acc,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_s,
    input  logic [DW-1:0] alu_z,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_zero,
    output logic          res_neg,
    output logic [DW-1:0] acc
);

    state_t state;
    state_t next_state;

    cmd_t   wr_cmd;
    cmd_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   load;
    logic   capture;
    logic   release_res;

    assign wr_cmd    = '{acc_sel: cmd_acc, op: cmd_op, a: cmd_a, b: cmd_b};
    assign cmd_ready = !fifo_full;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .pop   (pop),
        .wdata (wr_cmd),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath controls
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        load        = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        load       = 1'b1;
                        next_state = EXEC;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ALU operand/select registers; hold their last values outside a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_s <= '0;
        end else if (load) begin
            alu_a <= pick_a(head, acc);
            alu_b <= head.b;
            alu_s <= head.op;
        end
    end

    // Result register, flags and accumulator; valid drops on downstream acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
            res_valid <= 1'b0;
            acc       <= '0;
        end else if (capture) begin
            res_data  <= alu_z;
            acc       <= alu_z;
            res_zero  <= (alu_z == '0);
            res_neg   <= alu_z[DW-1];
            res_valid <= 1'b1;
        end else if (release_res) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Testbench for alu_cmd_seq with a behavioural 8-bit ALU between alu_a/b/s and alu_z.
module tb_alu_cmd_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_s;
    logic [7:0] alu_z;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic       res_neg;
    logic [7:0] acc;

    int total = 0;
    int bad   = 0;

    alu_cmd_seq #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_acc   (cmd_acc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_z     (alu_z),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_neg   (res_neg),
        .acc       (acc)
    );

    // The ALU: combinational from alu_a/alu_b/alu_s
    always_comb begin
        alu_z = 8'h00;
        case (alu_s)
            3'd0: alu_z = 8'h00;
            3'd1: alu_z = alu_b - alu_a;
            3'd2: alu_z = alu_a - alu_b;
            3'd3: alu_z = alu_a + alu_b;
            3'd4: alu_z = alu_a ^ alu_b;
            3'd5: alu_z = alu_a | alu_b;
            3'd6: alu_z = alu_a & alu_b;
            3'd7: alu_z = 8'hFF;
            default: alu_z = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       acc_sel;
        logic [7:0] exp_a;
        logic [7:0] exp_z;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic sel);
        cmd_op  = op;
        cmd_a   = a;
        cmd_b   = b;
        cmd_acc = sel;
    endtask

    // Single command from idle with res_ready high: fixed two-cycle latency
    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] z;
        z = v.exp_z;
        set_cmd(v.op, v.a, v.b, v.acc_sel);
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk({tag, "_valid_e0"}, res_valid, 0);
        tick();
        chk({tag, "_valid_e1"}, res_valid, 0);
        chk({tag, "_alu_a"}, alu_a, v.exp_a);
        chk({tag, "_alu_b"}, alu_b, v.b);
        chk({tag, "_alu_s"}, alu_s, v.op);
        tick();
        chk({tag, "_valid_e2"}, res_valid, 1);
        chk({tag, "_data"}, res_data, z);
        chk({tag, "_zero"}, res_zero, (z == 8'h00));
        chk({tag, "_neg"}, res_neg, z[7]);
        chk({tag, "_acc"}, acc, z);
        tick();
        chk({tag, "_valid_e3"}, res_valid, 0);
    endtask

    initial begin
        logic [7:0] bp_exp[5];
        logic [7:0] got[$];
        int         gotcyc[$];
        logic [7:0] sb[$];
        logic [7:0] a_v;
        logic [7:0] e_v;
        int         n;
        logic       stray;

        //          op    a      b      sel   exp_a  exp_z
        vecs[0]  = '{3'd3, 8'h7F, 8'h01, 1'b0, 8'h7F, 8'h80};
        vecs[1]  = '{3'd3, 8'h05, 8'h03, 1'b0, 8'h05, 8'h08};
        vecs[2]  = '{3'd2, 8'hEE, 8'h08, 1'b1, 8'h08, 8'h00};
        vecs[3]  = '{3'd1, 8'h01, 8'h00, 1'b0, 8'h01, 8'hFF};
        vecs[4]  = '{3'd7, 8'h12, 8'h34, 1'b0, 8'h12, 8'hFF};
        vecs[5]  = '{3'd0, 8'h56, 8'h78, 1'b0, 8'h56, 8'h00};
        vecs[6]  = '{3'd4, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'h00};
        vecs[7]  = '{3'd5, 8'h0F, 8'h30, 1'b0, 8'h0F, 8'h3F};
        vecs[8]  = '{3'd6, 8'hF0, 8'h3C, 1'b0, 8'hF0, 8'h30};
        vecs[9]  = '{3'd2, 8'h10, 8'h20, 1'b0, 8'h10, 8'hF0};
        vecs[10] = '{3'd3, 8'h00, 8'h10, 1'b1, 8'hF0, 8'h00};
        vecs[11] = '{3'd1, 8'h77, 8'h05, 1'b1, 8'h00, 8'h05};

        // results expected from the backpressure burst, in order
        bp_exp[0] = 8'h11;
        bp_exp[1] = 8'hFF;
        bp_exp[2] = 8'h5A;
        bp_exp[3] = 8'h06;
        bp_exp[4] = 8'h3C;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        set_cmd(3'd0, 8'h00, 8'h00, 1'b0);

        // Reset state
        #12;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_s", alu_s, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_zero", res_zero, 0);
        chk("rst_res_neg", res_neg, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed single-command vectors
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: five commands with res_ready low fill in-flight + 4 queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_cmd(3'd3, 8'h10, 8'h01, 1'b0);
                1: set_cmd(3'd5, 8'h0F, 8'hF0, 1'b0);
                2: set_cmd(3'd6, 8'hFF, 8'h5A, 1'b0);
                3: set_cmd(3'd1, 8'h99, 8'h60, 1'b1);
                default: set_cmd(3'd4, 8'h33, 8'h0F, 1'b0);
            endcase
            cmd_valid = 1'b1;
            chk($sformatf("bp_ready_%0d", i), cmd_ready, 1);
            tick();
        end
        chk("bp_full", cmd_ready, 0);
        set_cmd(3'd3, 8'h99, 8'h00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_still_full", cmd_ready, 0);
        chk("bp_hold_valid", res_valid, 1);
        chk("bp_hold_data", res_data, 8'h11);
        res_ready = 1'b1;
        for (int c = 0; c < 30 && got.size() < 5; c++) begin
            if (res_valid) begin
                got.push_back(res_data);
                gotcyc.push_back(c);
            end
            tick();
        end
        chk("bp_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) begin
            chk($sformatf("bp_res_%0d", i), got[i], bp_exp[i]);
            if (i > 0) begin
                chk($sformatf("bp_gap_%0d", i), gotcyc[i] - gotcyc[i-1], 2);
            end
        end
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid) stray = 1'b1;
            tick();
        end
        chk("bp_no_extra", stray, 0);

        // Async reset during EXEC with three commands queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(3'd3, 8'h40 + 8'(i), 8'h02, 1'b0);
            cmd_valid = 1'b1;
            tick();
        end
        chk("ra_hold_valid", res_valid, 1);
        res_ready = 1'b1;
        set_cmd(3'd3, 8'h60, 8'h01, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("ra_in_exec", res_valid, 0);
        chk("ra_acc_before", acc, 8'h42);
        chk("ra_count_before", dut.u_fifo.count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_valid", res_valid, 0);
        chk("ra_acc", acc, 0);
        chk("ra_cmd_ready", cmd_ready, 1);
        chk("ra_alu_a", alu_a, 0);
        chk("ra_res_data", res_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        stray = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (res_valid) stray = 1'b1;
            tick();
        end
        chk("ra_no_stale", stray, 0);
        run_vec('{3'd3, 8'hAA, 8'h07, 1'b1, 8'h00, 8'h07}, "ra_fresh");

        // Steady push/pop at count 2: pointers wrap, order checked against a scoreboard
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_v = 8'(i * 8'h13);
            set_cmd(3'd3, a_v, 8'h05, 1'b0);
            cmd_valid = 1'b1;
            chk($sformatf("pp_setup_ready_%0d", i), cmd_ready, 1);
            sb.push_back(a_v + 8'h05);
            tick();
        end
        cmd_valid = 1'b0;
        chk("pp_setup_valid", res_valid, 1);
        res_ready = 1'b1;
        n = 3;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("pp_count_%0d", c), dut.u_fifo.count, 2);
            if (res_valid) begin
                e_v = (sb.size() > 0) ? sb.pop_front() : 8'h00;
                chk($sformatf("pp_res_%0d", c), res_data, e_v);
                a_v = 8'(n * 8'h13);
                set_cmd(3'd3, a_v, 8'h05, 1'b0);
                cmd_valid = 1'b1;
                chk($sformatf("pp_ready_%0d", c), cmd_ready, 1);
                sb.push_back(a_v + 8'h05);
                n++;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            if (res_valid) begin
                e_v = sb.pop_front();
                chk($sformatf("pp_drain_%0d", c), res_data, e_v);
            end
            tick();
        end
        chk("pp_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
Name: alu_cmd_seq

Overview:
- Command sequencer that sits directly upstream of the 8-bit ALU (inputs a, b, 3-bit select s; output z).
- Buffers incoming operation commands in a small FIFO and issues them to the ALU one at a time.
- Captures z into a result register with zero/negative flags and an 8-bit accumulator, then hands the result downstream over a valid/ready handshake.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
AW, 2, FIFO pointer width = log2(DEPTH)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (= not full)
cmd_op  input  3  ALU select: 0 clear, 1 b-a, 2 a-b, 3 a+b, 4 xor, 5 or, 6 and, 7 preset
cmd_a  input  8  operand a
cmd_b  input  8  operand b
cmd_acc  input  1  1: use accumulator instead of cmd_a as operand a
alu_a  output  8  registered operand a to ALU
alu_b  output  8  registered operand b to ALU
alu_s  output  3  registered select to ALU
alu_z  input  8  ALU result (combinational from alu_a/alu_b/alu_s)
res_valid  output  1  result held
res_ready  input  1  downstream accepts
res_data  output  8  captured result
res_zero  output  1  res_data == 0
res_neg  output  1  res_data[7]
acc  output  8  accumulator (last captured result)

Behaviour:
Reset (rst_n low, asynchronous):
- Outputs: alu_a=0, alu_b=0, alu_s=0, res_data=0, res_zero=0, res_neg=0, res_valid=0, acc=0.
- FIFO empty, cmd_ready=1, FSM=IDLE.
- Reset mid-operation discards all queued and in-flight commands.

FIFO:
- Push when cmd_valid & cmd_ready.
- cmd_ready = !full. Full decided from count register, so there is no push-through-full even if a pop occurs the same cycle.
- Entry = {acc_sel, op, a, b} = 20 bits.
- Pointers wrap modulo DEPTH. Count range 0..DEPTH.
- Simultaneous push and pop when not full and not empty: count unchanged.

FSM states IDLE, EXEC, HOLD:
- IDLE: if FIFO not empty, pop the head:
  - alu_s <= op, alu_b <= b, alu_a <= (acc_sel ? acc : a).
  - Go to EXEC. Otherwise stay in IDLE.
- EXEC (ALU inputs stable for one full cycle):
  - res_data <= alu_z, acc <= alu_z, res_zero <= (alu_z==0), res_neg <= alu_z[7], res_valid <= 1.
  - Go to HOLD.
- HOLD (res_valid=1, res_data/flags stable):
  - If res_ready and FIFO not empty: res_valid <= 0, pop and load the ALU registers as in IDLE (acc_sel uses the updated acc), go to EXEC.
  - If res_ready and FIFO empty: res_valid <= 0, go to IDLE.
  - If !res_ready: hold all state.

Timing and ordering:
- Latency: command accepted at edge E with the FSM idle and FIFO empty -> ALU registers loaded at E+1 -> res_valid=1 from E+2.
- Throughput: one result per 2 cycles with res_ready held high.
- Exactly one op in flight, so there is no accumulator hazard: a cmd_acc command always sees the result of the immediately preceding command.
- Results are delivered in command order. No command is dropped or duplicated.
- alu_a/alu_b/alu_s hold their last values in IDLE and HOLD.

Arithmetic:
- All 8-bit, modulo 256; the ALU owns wrap.
- Flags are derived from the captured z only. There is no carry or overflow output.

Decomposition:
- Shared package: op encodings OP_CLR=3'd0, OP_BSUBA=3'd1, OP_ASUBB=3'd2, OP_ADD=3'd3, OP_XOR=3'd4, OP_OR=3'd5, OP_AND=3'd6, OP_SET=3'd7; FSM state encoding; data width constant 8.
- One sub-module: alu_cmd_fifo (parameterised DEPTH, synchronous FIFO with count, full/empty).
- FSM, accumulator and result register stay in alu_cmd_seq.
- The bench instantiates the existing ALU between alu_a/alu_b/alu_s and alu_z.

Test Plan:
- Reset then single cmd op=3, a=8'h7F, b=8'h01, res_ready=1 -> res_valid high 2 cycles after accept, res_data=8'h80, res_neg=1, res_zero=0, acc=8'h80.
- Chain: op=3 a=5 b=3, then op=2 cmd_acc=1 b=8 -> results 8'h08 then 8'h00 with res_zero=1; second alu_a driven 8'h08.
- Backpressure: res_ready=0, push 5 commands with DEPTH=4 -> cmd_ready drops after 4 are queued beyond the in-flight one; release res_ready -> 5 results in order, one per 2 cycles.
- Wrap/boundaries: op=1 a=1 b=0 -> 8'hFF (res_neg=1); op=7 -> 8'hFF; op=0 -> 8'h00 (res_zero=1); op=4 a=b=8'hA5 -> 8'h00.
- Async reset asserted mid-EXEC with 3 queued -> immediately res_valid=0, acc=0, cmd_ready=1; after release no stale results emerge.
- Simultaneous push and pop at count=2 over 10 cycles -> count stays stable, pointers wrap past DEPTH-1, data integrity checked against a scoreboard.
